// File: rtl/sync_fifo_param.sv
// Single-clock FIFO with arbitrary depth, threshold flags, sticky error flags
// and a selectable registered-read or first-word-fall-through read port.
module sync_fifo_param #(
   parameter int unsigned DATA_WIDTH = 6,
   parameter int unsigned DEPTH      = 4,
   parameter int unsigned AF_LEVEL   = DEPTH - 1,
   parameter int unsigned AE_LEVEL   = 1,
   parameter bit          FWFT       = 1'b0
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic                               wr_en,
   input  logic [DATA_WIDTH-1:0]              wr_data,
   input  logic                               rd_en,
   input  logic                               clr_err,
   output logic [DATA_WIDTH-1:0]              rd_data,
   output logic                               rd_valid,
   output logic                               full,
   output logic                               empty,
   output logic                               almost_full,
   output logic                               almost_empty,
   output logic [$clog2(DEPTH+1)-1:0]         count,
   output logic                               overflow,
   output logic                               underflow
);

   localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = $clog2(DEPTH + 1);

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]         wr_ptr;
   logic [PW-1:0]         rd_ptr;

   logic                  do_wr_c;
   logic                  do_rd_c;
   logic [PW-1:0]         wr_ptr_nxt_c;
   logic [PW-1:0]         rd_ptr_nxt_c;
   logic [CW-1:0]         count_nxt_c;
   logic [DATA_WIDTH-1:0] rd_data_nxt_c;
   logic                  rd_valid_nxt_c;
   logic                  overflow_nxt_c;
   logic                  underflow_nxt_c;

   // Modulo-DEPTH increment; DEPTH need not be a power of two.
   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   // Request acceptance, pointer and occupancy next-state.
   always_comb begin
      do_rd_c      = rd_en && !empty;
      do_wr_c      = wr_en && (!full || do_rd_c);
      wr_ptr_nxt_c = do_wr_c ? ptr_inc(wr_ptr) : wr_ptr;
      rd_ptr_nxt_c = do_rd_c ? ptr_inc(rd_ptr) : rd_ptr;
      count_nxt_c  = count;
      if (do_wr_c && !do_rd_c) begin
         count_nxt_c = count + CW'(1);
      end else if (!do_wr_c && do_rd_c) begin
         count_nxt_c = count - CW'(1);
      end
   end

   // Sticky errors: a new error wins over a simultaneous clear.
   always_comb begin
      overflow_nxt_c  = (overflow  && !clr_err) || (wr_en && !do_wr_c);
      underflow_nxt_c = (underflow && !clr_err) || (rd_en && empty);
   end

   // Read port next-state. In FWFT mode the new head may be the word being
   // written this cycle (empty, or last word popped while writing), so bypass.
   always_comb begin
      rd_data_nxt_c  = rd_data;
      rd_valid_nxt_c = 1'b0;
      if (FWFT) begin
         rd_valid_nxt_c = (count_nxt_c != '0);
         if (count_nxt_c != '0) begin
            if (do_wr_c && (wr_ptr == rd_ptr_nxt_c)) begin
               rd_data_nxt_c = wr_data;
            end else begin
               rd_data_nxt_c = mem[rd_ptr_nxt_c];
            end
         end
      end else begin
         rd_valid_nxt_c = do_rd_c;
         if (do_rd_c) begin
            rd_data_nxt_c = mem[rd_ptr];
         end
      end
   end

   // Storage is not reset; writes are suppressed while in reset.
   always_ff @(posedge clk) begin
      if (!rst && do_wr_c) begin
         mem[wr_ptr] <= wr_data;
      end
   end

   // Control state and registered flags.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         count        <= '0;
         full         <= 1'b0;
         empty        <= 1'b1;
         almost_full  <= 1'b0;
         almost_empty <= 1'b1;
         rd_data      <= '0;
         rd_valid     <= 1'b0;
         overflow     <= 1'b0;
         underflow    <= 1'b0;
      end else begin
         wr_ptr       <= wr_ptr_nxt_c;
         rd_ptr       <= rd_ptr_nxt_c;
         count        <= count_nxt_c;
         full         <= (count_nxt_c == CW'(DEPTH));
         empty        <= (count_nxt_c == '0);
         almost_full  <= (32'(count_nxt_c) >= AF_LEVEL);
         almost_empty <= (32'(count_nxt_c) <= AE_LEVEL);
         rd_data      <= rd_data_nxt_c;
         rd_valid     <= rd_valid_nxt_c;
         overflow     <= overflow_nxt_c;
         underflow    <= underflow_nxt_c;
      end
   end

endmodule

// File: doc/sync_fifo_param.md
SYNC_FIFO_PARAM -- requirements
Module: sync_fifo_param

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 6, word width in bits (>=1).
REQ-002 SHALL have parameter DEPTH, default 4, number of entries (>=2, not required to be a power of two).
REQ-003 SHALL have parameter AF_LEVEL, default DEPTH-1, count at or above which almost_full asserts.
REQ-004 SHALL have parameter AE_LEVEL, default 1, count at or below which almost_empty asserts.
REQ-005 SHALL have parameter FWFT, default 0, read mode (0 = registered read, 1 = first-word-fall-through).
REQ-006 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-007 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-008 SHALL have port wr_en  input  1  write request.
REQ-009 SHALL have port wr_data  input  DATA_WIDTH  write word.
REQ-010 SHALL have port rd_en  input  1  read request (pop).
REQ-011 SHALL have port clr_err  input  1  clears sticky error flags.
REQ-012 SHALL have port rd_data  output  DATA_WIDTH  read word.
REQ-013 SHALL have port rd_valid  output  1  rd_data is valid.
REQ-014 SHALL have port full / empty  output  1 each  occupancy flags.
REQ-015 SHALL have port almost_full / almost_empty  output  1 each  threshold flags.
REQ-016 SHALL have port count  output  $clog2(DEPTH+1)  current occupancy.
REQ-017 SHALL have port overflow / underflow  output  1 each  sticky error flags.

Function
REQ-018 SHALL accept a write when wr_en=1 and (full=0 or a read is accepted in the same cycle); storage takes wr_data at wr_ptr, wr_ptr advances.
REQ-019 SHALL accept a read when rd_en=1 and empty=0; rd_ptr advances. A write to an empty FIFO in the same cycle does not make that read acceptable.
REQ-020 SHALL wrap wr_ptr/rd_ptr from DEPTH-1 to 0 (modulo DEPTH, no power-of-two assumption).
REQ-021 SHALL update count: +1 on write only, -1 on read only, unchanged when both accepted or neither.
REQ-022 SHALL drive full = (count==DEPTH), empty = (count==0), almost_full = (count>=AF_LEVEL), almost_empty = (count<=AE_LEVEL), all derived from registered count.
REQ-023 FWFT=0: on an accepted read, rd_data SHALL register the head word and rd_valid SHALL be 1 the following cycle only; otherwise rd_valid=0 and rd_data holds its last value.
REQ-024 FWFT=1: rd_data SHALL present the head word whenever empty=0, rd_valid SHALL equal !empty, rd_en pops it; a word written into an empty FIFO becomes visible the cycle after the write.
REQ-025 SHALL set overflow when wr_en=1 and the write is not accepted; SHALL set underflow when rd_en=1 and empty=1; both hold until clr_err=1 or rst=1.
REQ-026 SHALL give set priority over clr_err when an error occurs in the same cycle as clr_err=1.
REQ-027 SHALL leave storage and pointers unchanged by rejected requests.

Reset
REQ-028 With rst=1 at a rising edge, SHALL set wr_ptr=0, rd_ptr=0, count=0, empty=1, full=0, almost_full=0, almost_empty=1, rd_valid=0, rd_data=0, overflow=0, underflow=0.
REQ-029 Reset SHALL take priority over all requests in the same cycle, including mid-stream; storage contents need not be cleared.

Verification (DEPTH=4, DATA_WIDTH=6, AF_LEVEL=3, AE_LEVEL=1)
REQ-030 FWFT=0: write 0x05,0x0A,0x15 then read 3 -> rd_data 0x05,0x0A,0x15 each one cycle after rd_en with rd_valid=1; empty=1 at end.
REQ-031 Fill 4 words -> full=1, almost_full asserted at count=3; fifth write -> overflow=1, count stays 4; clr_err -> overflow=0.
REQ-032 Read when empty -> underflow=1, rd_valid=0, count 0; simultaneous wr_en+rd_en while empty -> write accepted, underflow=1, count=1.
REQ-033 Full FIFO, wr_en+rd_en together -> both accepted, count stays 4, overflow=0; repeat 6 cycles -> pointers wrap, data order preserved.
REQ-034 FWFT=1: write 0x2A into empty -> next cycle rd_valid=1, rd_data=0x2A with no rd_en; rd_en -> empty=1 next cycle.
REQ-035 Assert rst with count=2 and overflow=1 -> next cycle all outputs at reset values of REQ-028.
